// File: rtl/register_file_mp_pkg.sv
// rf_pkg: shared defaults, address-width and packed-bus slice helpers for the register file
package rf_pkg;
    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NUM_REGS = 32;
    localparam int DEF_NUM_READ = 2;

    function automatic int addr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int slice_lo(input int port, input int w);
        return port * w;
    endfunction
endpackage

// File: rtl/register_file_mp_if.sv
// register_file_mp_if: read, write and issue signals between decode/writeback and the register file
interface register_file_mp_if
    import rf_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int AW       = addr_width(NUM_REGS)
);
    logic [NUM_READ*AW-1:0]    ra;
    logic [NUM_READ*WIDTH-1:0] rd;
    logic [NUM_READ-1:0]       rd_busy;
    logic                      we_a;
    logic [AW-1:0]             wa_a;
    logic [WIDTH-1:0]          wd_a;
    logic                      we_b;
    logic [AW-1:0]             wa_b;
    logic [WIDTH-1:0]          wd_b;
    logic                      issue_en;
    logic [AW-1:0]             issue_addr;
    logic                      issue_ready;
    logic                      wr_conflict;

    modport master (
        output ra, we_a, wa_a, wd_a, we_b, wa_b, wd_b, issue_en, issue_addr,
        input  rd, rd_busy, issue_ready, wr_conflict
    );

    modport slave (
        input  ra, we_a, wa_a, wd_a, we_b, wa_b, wd_b, issue_en, issue_addr,
        output rd, rd_busy, issue_ready, wr_conflict
    );
endinterface

// File: rtl/register_file_mp_scoreboard.sv
// rf_scoreboard: per-register pending-write bits; a new issue outranks a same-cycle writeback
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int ZERO_REG = 1,
    parameter int AW       = addr_width(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_en,
    input  logic [AW-1:0]       issue_addr,
    input  logic                we_a,
    input  logic [AW-1:0]       wa_a,
    input  logic                we_b,
    input  logic [AW-1:0]       wa_b,
    output logic [NUM_REGS-1:0] busy,
    output logic                issue_ready
);
    logic [NUM_REGS-1:0] busy_d;
    logic                issue_zero;
    logic                issue_go;

    assign issue_zero  = (ZERO_REG != 0) && (issue_addr == '0);
    assign issue_ready = issue_zero | ~busy[issue_addr];
    assign issue_go    = issue_en & issue_ready & ~issue_zero;

    always_comb begin
        busy_d = busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (issue_go && issue_addr == AW'(r))
                busy_d[r] = 1'b1;
            else if ((we_a && wa_a == AW'(r)) || (we_b && wa_b == AW'(r)))
                busy_d[r] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_d;
    end
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port register file with dual writeback, optional bypass/zero register
// and an integrated RAW/WAW scoreboard
module register_file_mp
    import rf_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_READ = DEF_NUM_READ,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic               clk,
    input  logic               rst,
    register_file_mp_if.slave  bus
);
    localparam int AW = addr_width(NUM_REGS);

    logic [WIDTH-1:0]    mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wen_a;
    logic                wen_b;
    logic                same_addr;
    logic                wr_conflict_q;

    assign same_addr = bus.wa_a == bus.wa_b;
    assign wen_a     = bus.we_a & ~((ZERO_REG != 0) && bus.wa_a == '0);
    // port B yields to port A on a shared destination
    assign wen_b     = bus.we_b & ~((ZERO_REG != 0) && bus.wa_b == '0) & ~(wen_a & same_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                mem[r] <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            if (wen_a)
                mem[bus.wa_a] <= bus.wd_a;
            if (wen_b)
                mem[bus.wa_b] <= bus.wd_b;
            if (wen_a && bus.we_b && same_addr)
                wr_conflict_q <= 1'b1;
        end
    end

    assign bus.wr_conflict = wr_conflict_q;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_en    (bus.issue_en),
        .issue_addr  (bus.issue_addr),
        .we_a        (bus.we_a),
        .wa_a        (bus.wa_a),
        .we_b        (bus.we_b),
        .wa_b        (bus.wa_b),
        .busy        (busy),
        .issue_ready (bus.issue_ready)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [AW-1:0] addr;
        logic          zero;
        logic          hit_a;
        logic          hit_b;
        assign addr  = bus.ra[slice_lo(i, AW) +: AW];
        assign zero  = (ZERO_REG != 0) && addr == '0;
        assign hit_a = (BYPASS != 0) && wen_a && bus.wa_a == addr;
        assign hit_b = (BYPASS != 0) && wen_b && bus.wa_b == addr;
        assign bus.rd[slice_lo(i, WIDTH) +: WIDTH] = zero  ? '0 :
                                                     hit_a ? bus.wd_a :
                                                     hit_b ? bus.wd_b : mem[addr];
        assign bus.rd_busy[i] = ~zero & ~hit_a & ~hit_b & busy[addr];
    end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: directed scenario tasks with hand-computed expectations for register_file_mp
module tb_register_file_mp;
    localparam int WIDTH = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    register_file_mp_if #(.WIDTH(WIDTH), .NUM_REGS(NREGS), .NUM_READ(NREAD)) bus ();

    register_file_mp #(
        .WIDTH    (WIDTH),
        .NUM_REGS (NREGS),
        .NUM_READ (NREAD),
        .ZERO_REG (1),
        .BYPASS   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        bus.ra = {a1, a0};
        #1;
    endtask

    task automatic idle();
        bus.we_a = 1'b0;
        bus.we_b = 1'b0;
        bus.issue_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            bus.issue_addr = AW'(r);
            set_ra(AW'(r), AW'(r));
            checks++; if (bus.rd[31:0] !== 32'h0) begin errors++; $display("FAIL reset_rd0 r%0d: got %h expected 00000000", r, bus.rd[31:0]); end
            checks++; if (bus.rd[63:32] !== 32'h0) begin errors++; $display("FAIL reset_rd1 r%0d: got %h expected 00000000", r, bus.rd[63:32]); end
            checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL reset_busy r%0d: got %b expected 00", r, bus.rd_busy); end
            checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready r%0d: got %b expected 1", r, bus.issue_ready); end
        end
        checks++; if (bus.wr_conflict !== 1'b0) begin errors++; $display("FAIL reset_conflict: got %b expected 0", bus.wr_conflict); end
    endtask

    task automatic test_bypass();
        bus.we_a = 1'b1; bus.wa_a = 5'd3; bus.wd_a = 32'h0000000F;
        bus.we_b = 1'b1; bus.wa_b = 5'd4; bus.wd_b = 32'h00000044;
        set_ra(5'd3, 5'd4);
        checks++; if (bus.rd[31:0] !== 32'h0000000F) begin errors++; $display("FAIL bypass_a_same_cycle: got %h expected 0000000f", bus.rd[31:0]); end
        checks++; if (bus.rd[63:32] !== 32'h00000044) begin errors++; $display("FAIL bypass_b_same_cycle: got %h expected 00000044", bus.rd[63:32]); end
        step();
        idle();
        #1;
        checks++; if (bus.rd[31:0] !== 32'h0000000F) begin errors++; $display("FAIL stored_r3: got %h expected 0000000f", bus.rd[31:0]); end
        checks++; if (bus.rd[63:32] !== 32'h00000044) begin errors++; $display("FAIL stored_r4: got %h expected 00000044", bus.rd[63:32]); end
    endtask

    task automatic test_conflict();
        bus.we_a = 1'b1; bus.wa_a = 5'd5; bus.wd_a = 32'hAAAA0000;
        bus.we_b = 1'b1; bus.wa_b = 5'd5; bus.wd_b = 32'h5555FFFF;
        set_ra(5'd5, 5'd5);
        checks++; if (bus.rd[31:0] !== 32'hAAAA0000) begin errors++; $display("FAIL conflict_bypass: got %h expected aaaa0000", bus.rd[31:0]); end
        step();
        idle();
        #1;
        checks++; if (bus.rd[31:0] !== 32'hAAAA0000) begin errors++; $display("FAIL conflict_a_wins: got %h expected aaaa0000", bus.rd[31:0]); end
        checks++; if (bus.wr_conflict !== 1'b1) begin errors++; $display("FAIL conflict_set: got %b expected 1", bus.wr_conflict); end
        repeat (10) step();
        checks++; if (bus.wr_conflict !== 1'b1) begin errors++; $display("FAIL conflict_sticky: got %b expected 1", bus.wr_conflict); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        checks++; if (bus.wr_conflict !== 1'b0) begin errors++; $display("FAIL conflict_cleared: got %b expected 0", bus.wr_conflict); end
        checks++; if (bus.rd[31:0] !== 32'h0) begin errors++; $display("FAIL conflict_reg_reset: got %h expected 00000000", bus.rd[31:0]); end
    endtask

    task automatic test_scoreboard();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd7;
        set_ra(5'd7, 5'd0);
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL sb_ready_first: got %b expected 1", bus.issue_ready); end
        step();
        checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_busy_set: got %b expected 1", bus.rd_busy[0]); end
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL sb_waw_stall: got %b expected 0", bus.issue_ready); end
        step();
        bus.issue_en = 1'b0;
        #1;
        checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_busy_held: got %b expected 1", bus.rd_busy[0]); end
        bus.we_b = 1'b1; bus.wa_b = 5'd7; bus.wd_b = 32'h00001234;
        #1;
        checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_busy_bypassed: got %b expected 0", bus.rd_busy[0]); end
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL sb_ready_no_lookthrough: got %b expected 0", bus.issue_ready); end
        step();
        idle();
        #1;
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL sb_ready_after_wb: got %b expected 1", bus.issue_ready); end
        checks++; if (bus.rd_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_busy_cleared: got %b expected 0", bus.rd_busy[0]); end
        checks++; if (bus.rd[31:0] !== 32'h00001234) begin errors++; $display("FAIL sb_wb_data: got %h expected 00001234", bus.rd[31:0]); end
    endtask

    task automatic test_set_wins();
        bus.issue_en = 1'b1; bus.issue_addr = 5'd9;
        bus.we_a = 1'b1; bus.wa_a = 5'd9; bus.wd_a = 32'h00000099;
        step();
        idle();
        set_ra(5'd9, 5'd0);
        checks++; if (bus.rd[31:0] !== 32'h00000099) begin errors++; $display("FAIL setwins_data: got %h expected 00000099", bus.rd[31:0]); end
        checks++; if (bus.rd_busy[0] !== 1'b1) begin errors++; $display("FAIL setwins_busy: got %b expected 1", bus.rd_busy[0]); end
        checks++; if (bus.issue_ready !== 1'b0) begin errors++; $display("FAIL setwins_ready: got %b expected 0", bus.issue_ready); end
    endtask

    task automatic test_zero_reg();
        bus.we_a = 1'b1; bus.wa_a = 5'd0; bus.wd_a = 32'hDEADBEEF;
        bus.we_b = 1'b1; bus.wa_b = 5'd0; bus.wd_b = 32'h00000001;
        bus.issue_en = 1'b1; bus.issue_addr = 5'd0;
        set_ra(5'd0, 5'd0);
        checks++; if (bus.rd[31:0] !== 32'h0) begin errors++; $display("FAIL zero_no_bypass: got %h expected 00000000", bus.rd[31:0]); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", bus.issue_ready); end
        step();
        idle();
        #1;
        checks++; if (bus.rd[63:32] !== 32'h0) begin errors++; $display("FAIL zero_rd: got %h expected 00000000", bus.rd[63:32]); end
        checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL zero_busy: got %b expected 00", bus.rd_busy); end
        checks++; if (bus.wr_conflict !== 1'b0) begin errors++; $display("FAIL zero_conflict: got %b expected 0", bus.wr_conflict); end
    endtask

    task automatic test_reset_mid();
        bus.we_a = 1'b1; bus.wa_a = 5'd10; bus.wd_a = 32'h00000010;
        step();
        bus.wa_a = 5'd11; bus.wd_a = 32'h00000011;
        bus.issue_en = 1'b1; bus.issue_addr = 5'd12;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle();
        set_ra(5'd10, 5'd11);
        checks++; if (bus.rd[31:0] !== 32'h0) begin errors++; $display("FAIL rstmid_r10: got %h expected 00000000", bus.rd[31:0]); end
        checks++; if (bus.rd[63:32] !== 32'h0) begin errors++; $display("FAIL rstmid_r11: got %h expected 00000000", bus.rd[63:32]); end
        set_ra(5'd9, 5'd12);
        checks++; if (bus.rd[31:0] !== 32'h0) begin errors++; $display("FAIL rstmid_r9: got %h expected 00000000", bus.rd[31:0]); end
        checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL rstmid_busy: got %b expected 00", bus.rd_busy); end
        checks++; if (bus.issue_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", bus.issue_ready); end
    endtask

    initial begin
        bus.ra = '0;
        bus.we_a = 1'b0; bus.wa_a = '0; bus.wd_a = '0;
        bus.we_b = 1'b0; bus.wa_b = '0; bus.wd_b = '0;
        bus.issue_en = 1'b0; bus.issue_addr = '0;
        test_reset();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_set_wins();
        test_zero_reg();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
